ex_mem_exc_stage: RTL and testbench

EX/MEM pipeline register and exception-collection stage that feeds the CP0 block. It latches the instruction leaving EX and resolves its exception sources by priority, including data-address alignment and interrupt injection. It tracks delay-slot status across bubbles and stalls, then presents one-shot exception or eret commit pulses to CP0 and a pipeline flush with redirect PC to the front end.

---
 rtl/ex_mem_exc_stage.sv | 161 ++++++++++++++++
 tb/tb_ex_mem_exc_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_exc_stage.sv
// EX/MEM pipeline register with exception collection for CP0.
// Resolves exception sources by priority, tracks delay-slot status and
// produces one-shot exception/eret commits plus a front-end flush.
module ex_mem_exc_stage #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_adel_if,
  input  logic        ex_ri,
  input  logic        ex_ov,
  input  logic        ex_sys,
  input  logic        ex_bp,
  input  logic        ex_eret,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [31:0] ex_mem_addr,
  input  logic [1:0]  ex_mem_size,
  input  logic        mem_stall,
  input  logic        cp0_interrupt,
  input  logic [31:0] epc_in,
  output logic        EX_MEM_valid,
  output logic [31:0] EX_MEM_PC,
  output logic        EX_MEM_bd,
  output logic        EX_MEM_Exc,
  output logic [4:0]  EX_MEM_ExcCode,
  output logic [31:0] EX_MEM_badvaddr,
  output logic        EX_MEM_eret_flush,
  output logic        mem_req_kill,
  output logic        pipe_flush,
  output logic [31:0] flush_pc
);

  // RUN: the MEM instruction has not committed yet; HELD: it already
  // committed while stalled and must not pulse again.
  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_bd;
  logic        r_exc;
  logic [4:0]  r_code;
  logic [31:0] r_badvaddr;
  logic        r_eret;
  logic        r_prevBr;

  logic        w_misaligned;
  logic        w_excHit;
  logic [4:0]  w_excCode;
  logic [31:0] w_badvaddr;
  logic        w_enter;
  logic        w_load;
  logic        w_reported;

  assign w_load     = ~mem_stall;
  assign w_enter    = ex_valid & ~pipe_flush;
  assign w_reported = (r_state == HELD);

  // Data alignment check and priority resolution of the EX exception sources.
  always_comb begin
    w_misaligned = ((ex_mem_size == 2'd1) & ex_mem_addr[0]) |
                   ((ex_mem_size == 2'd2) & (ex_mem_addr[1:0] != 2'b00));
    w_excHit   = 1'b1;
    w_excCode  = 5'd0;
    w_badvaddr = 32'd0;
    if (cp0_interrupt) begin
      w_excCode = 5'd0;
    end else if (ex_adel_if) begin
      w_excCode  = 5'd4;
      w_badvaddr = ex_pc;
    end else if (ex_ri) begin
      w_excCode = 5'd10;
    end else if (ex_ov) begin
      w_excCode = 5'd12;
    end else if (ex_sys) begin
      w_excCode = 5'd8;
    end else if (ex_bp) begin
      w_excCode = 5'd9;
    end else if (w_misaligned & ex_load) begin
      w_excCode  = 5'd4;
      w_badvaddr = ex_mem_addr;
    end else if (w_misaligned & ex_store) begin
      w_excCode  = 5'd5;
      w_badvaddr = ex_mem_addr;
    end else begin
      w_excHit = 1'b0;
    end
  end

  // MEM register: load the EX instruction (or a bubble) whenever MEM advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= 32'd0;
      r_bd       <= 1'b0;
      r_exc      <= 1'b0;
      r_code     <= 5'd0;
      r_badvaddr <= 32'd0;
      r_eret     <= 1'b0;
    end else if (w_load) begin
      r_valid    <= w_enter;
      r_pc       <= w_enter ? ex_pc : 32'd0;
      r_bd       <= w_enter & r_prevBr;
      r_exc      <= w_enter & w_excHit;
      r_code     <= w_enter ? w_excCode : 5'd0;
      r_badvaddr <= w_enter ? w_badvaddr : 32'd0;
      r_eret     <= w_enter & ex_eret;
    end
  end

  // Delay-slot tracker: remembers whether the last live instruction was a branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prevBr <= 1'b0;
    end else if (pipe_flush) begin
      r_prevBr <= 1'b0;
    end else if (w_load & w_enter) begin
      r_prevBr <= ex_is_branch;
    end
  end

  // Commit-tracking state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A new load re-arms the commit; a commit under stall suppresses repeats.
  always_comb begin
    w_stateNext = r_state;
    if (w_load) begin
      w_stateNext = RUN;
    end else if (pipe_flush) begin
      w_stateNext = HELD;
    end
  end

  assign EX_MEM_valid      = r_valid;
  assign EX_MEM_PC         = r_pc;
  assign EX_MEM_bd         = r_bd;
  assign EX_MEM_ExcCode    = r_code;
  assign EX_MEM_badvaddr   = r_badvaddr;
  assign EX_MEM_Exc        = r_valid & r_exc & ~w_reported;
  assign EX_MEM_eret_flush = r_valid & r_eret & ~r_exc & ~w_reported;
  assign pipe_flush        = EX_MEM_Exc | EX_MEM_eret_flush;
  assign flush_pc          = r_exc ? EXC_VECTOR : epc_in;
  assign mem_req_kill      = r_valid & r_exc;

endmodule

// File: tb/tb_ex_mem_exc_stage.sv
// Testbench for ex_mem_exc_stage: directed vectors, a behavioural slot
// model compared every cycle, and literal expectations from worked examples.
module tb_ex_mem_exc_stage;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_adel_if;
  logic        ex_ri;
  logic        ex_ov;
  logic        ex_sys;
  logic        ex_bp;
  logic        ex_eret;
  logic        ex_load;
  logic        ex_store;
  logic [31:0] ex_mem_addr;
  logic [1:0]  ex_mem_size;
  logic        mem_stall;
  logic        cp0_interrupt;
  logic [31:0] epc_in;
  logic        EX_MEM_valid;
  logic [31:0] EX_MEM_PC;
  logic        EX_MEM_bd;
  logic        EX_MEM_Exc;
  logic [4:0]  EX_MEM_ExcCode;
  logic [31:0] EX_MEM_badvaddr;
  logic        EX_MEM_eret_flush;
  logic        mem_req_kill;
  logic        pipe_flush;
  logic [31:0] flush_pc;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  ex_mem_exc_stage #(.EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_adel_if(ex_adel_if), .ex_ri(ex_ri), .ex_ov(ex_ov), .ex_sys(ex_sys),
    .ex_bp(ex_bp), .ex_eret(ex_eret), .ex_load(ex_load), .ex_store(ex_store),
    .ex_mem_addr(ex_mem_addr), .ex_mem_size(ex_mem_size),
    .mem_stall(mem_stall), .cp0_interrupt(cp0_interrupt), .epc_in(epc_in),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_PC(EX_MEM_PC), .EX_MEM_bd(EX_MEM_bd),
    .EX_MEM_Exc(EX_MEM_Exc), .EX_MEM_ExcCode(EX_MEM_ExcCode),
    .EX_MEM_badvaddr(EX_MEM_badvaddr), .EX_MEM_eret_flush(EX_MEM_eret_flush),
    .mem_req_kill(mem_req_kill), .pipe_flush(pipe_flush), .flush_pc(flush_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Contents of the MEM slot as the model understands it.
  typedef struct {
    bit        valid;
    bit [31:0] pc;
    bit        bd;
    bit        exc;
    bit [4:0]  code;
    bit [31:0] bad;
    bit        eret;
  } slot_t;

  slot_t mSlot;
  bit    mAfterBranch;
  bit    mDone;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Walk the exception sources in priority order and take the first that fires.
  function automatic void classify(output bit hit, output bit [4:0] code, output bit [31:0] bad);
    bit       fires [7];
    bit [4:0] codes [7];
    bit       mis;
    mis = (ex_mem_size == 2'd1 && ex_mem_addr[0] == 1'b1) ||
          (ex_mem_size == 2'd2 && ex_mem_addr[1:0] != 2'b00);
    fires = '{cp0_interrupt, ex_adel_if, ex_ri, ex_ov, ex_sys, ex_bp, mis && (ex_load || ex_store)};
    codes = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, (ex_load ? 5'd4 : 5'd5)};
    hit = 0; code = 0; bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (fires[i] && !hit) begin
        hit  = 1;
        code = codes[i];
        if (i == 1) bad = ex_pc;
        if (i == 6) bad = ex_mem_addr;
      end
    end
  endfunction

  function automatic bit modelCommits();
    return mSlot.valid && !mDone && (mSlot.exc || mSlot.eret);
  endfunction

  // Model advance: what the MEM slot must hold after each edge.
  always @(posedge clk or posedge rst) begin
    bit        flushNow;
    bit        hit;
    bit [4:0]  code;
    bit [31:0] bad;
    if (rst) begin
      mSlot        = '{default: 0};
      mAfterBranch = 0;
      mDone        = 0;
    end else begin
      flushNow = modelCommits();
      if (!mem_stall) begin
        mSlot = '{default: 0};
        mDone = 0;
        if (ex_valid && !flushNow) begin
          classify(hit, code, bad);
          mSlot.valid = 1;
          mSlot.pc    = ex_pc;
          mSlot.bd    = mAfterBranch;
          mSlot.exc   = hit;
          mSlot.code  = code;
          mSlot.bad   = bad;
          mSlot.eret  = ex_eret;
          mAfterBranch = ex_is_branch;
        end
      end else if (flushNow) begin
        mDone = 1;
      end
      if (flushNow) mAfterBranch = 0;
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    bit eExc;
    bit eEret;
    eExc  = mSlot.valid && mSlot.exc && !mDone;
    eEret = mSlot.valid && mSlot.eret && !mSlot.exc && !mDone;
    checkOutput("mValid", EX_MEM_valid, mSlot.valid);
    checkOutput("mPC", EX_MEM_PC, mSlot.pc);
    checkOutput("mBd", EX_MEM_bd, mSlot.bd);
    checkOutput("mExc", EX_MEM_Exc, eExc);
    checkOutput("mCode", EX_MEM_ExcCode, mSlot.code);
    checkOutput("mBad", EX_MEM_badvaddr, mSlot.bad);
    checkOutput("mEret", EX_MEM_eret_flush, eEret);
    checkOutput("mFlush", pipe_flush, eExc || eEret);
    checkOutput("mFlushPc", flush_pc, mSlot.exc ? VEC : epc_in);
    checkOutput("mKill", mem_req_kill, mSlot.valid && mSlot.exc);
  end

  task automatic setIdle();
    ex_valid = 0; ex_pc = 0; ex_is_branch = 0; ex_adel_if = 0; ex_ri = 0;
    ex_ov = 0; ex_sys = 0; ex_bp = 0; ex_eret = 0; ex_load = 0; ex_store = 0;
    ex_mem_addr = 0; ex_mem_size = 0;
  endtask

  // Present the current EX inputs across one rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1; setIdle(); mem_stall = 0; cp0_interrupt = 0; epc_in = 32'h80002000;
    #3;
    checkOutput("rstValid", EX_MEM_valid, 0);
    checkOutput("rstExc", EX_MEM_Exc, 0);
    checkOutput("rstFlush", pipe_flush, 0);
    checkOutput("rstFlushPc", flush_pc, 32'h80002000);
    @(posedge clk); @(posedge clk); #1 rst = 0;

    // Misaligned word load
    ex_valid = 1; ex_pc = 32'h80001000; ex_load = 1; ex_mem_addr = 32'h1002; ex_mem_size = 2;
    applyStimulus();
    checkOutput("adelExc", EX_MEM_Exc, 1);
    checkOutput("adelCode", EX_MEM_ExcCode, 4);
    checkOutput("adelBad", EX_MEM_badvaddr, 32'h1002);
    checkOutput("adelKill", mem_req_kill, 1);
    checkOutput("adelFlushPc", flush_pc, 32'hBFC00380);
    setIdle(); applyStimulus();
    checkOutput("adelOneShot", EX_MEM_Exc, 0);

    // Branch, bubble, overflow in delay slot
    ex_valid = 1; ex_pc = 32'h80000100; ex_is_branch = 1; applyStimulus();
    setIdle(); applyStimulus();
    ex_valid = 1; ex_pc = 32'h80000104; ex_ov = 1; applyStimulus();
    checkOutput("ovBd", EX_MEM_bd, 1);
    checkOutput("ovCode", EX_MEM_ExcCode, 12);
    setIdle(); ex_valid = 1; ex_pc = 32'h80000108; applyStimulus();
    checkOutput("wrongPathBubble", EX_MEM_valid, 0);
    ex_pc = 32'h8000010C; applyStimulus();
    checkOutput("afterBd", EX_MEM_bd, 0);
    checkOutput("afterValid", EX_MEM_valid, 1);

    // Interrupt outranks RI and syscall
    setIdle(); ex_valid = 1; ex_pc = 32'h80000400; ex_ri = 1; ex_sys = 1; cp0_interrupt = 1;
    applyStimulus();
    checkOutput("intCode", EX_MEM_ExcCode, 0);
    setIdle(); cp0_interrupt = 0; applyStimulus();
    ex_valid = 1; ex_pc = 32'h80000404; ex_ri = 1; ex_sys = 1; applyStimulus();
    checkOutput("riCode", EX_MEM_ExcCode, 10);
    setIdle(); applyStimulus();

    // Interrupt waits through bubbles
    cp0_interrupt = 1; applyStimulus(); applyStimulus();
    checkOutput("intBubbleNoExc", EX_MEM_Exc, 0);
    ex_valid = 1; ex_pc = 32'h80000500; applyStimulus();
    checkOutput("intLateExc", EX_MEM_Exc, 1);
    checkOutput("intLateCode", EX_MEM_ExcCode, 0);
    setIdle(); cp0_interrupt = 0; applyStimulus();

    // Fetch error, syscall vs break, break alone, aligned accesses
    ex_valid = 1; ex_pc = 32'h80000601; ex_adel_if = 1; ex_ri = 1; applyStimulus();
    checkOutput("fetchCode", EX_MEM_ExcCode, 4);
    checkOutput("fetchBad", EX_MEM_badvaddr, 32'h80000601);
    setIdle(); applyStimulus();
    ex_valid = 1; ex_pc = 32'h80000700; ex_sys = 1; ex_bp = 1; applyStimulus();
    checkOutput("sysCode", EX_MEM_ExcCode, 8);
    setIdle(); applyStimulus();
    ex_valid = 1; ex_pc = 32'h80000704; ex_bp = 1; applyStimulus();
    checkOutput("bpCode", EX_MEM_ExcCode, 9);
    setIdle(); applyStimulus();
    ex_valid = 1; ex_pc = 32'h80000708; ex_load = 1; ex_mem_addr = 32'h3; ex_mem_size = 0;
    applyStimulus();
    checkOutput("byteNoExc", EX_MEM_Exc, 0);
    ex_pc = 32'h8000070C; ex_store = 1; ex_load = 0; ex_mem_addr = 32'h2; ex_mem_size = 1;
    applyStimulus();
    checkOutput("halfNoExc", EX_MEM_Exc, 0);

    // Misaligned half store held by a 3-cycle stall
    ex_pc = 32'h80000800; ex_mem_addr = 32'h3001; ex_mem_size = 1; applyStimulus();
    checkOutput("adesCode", EX_MEM_ExcCode, 5);
    pulses = int'(EX_MEM_Exc);
    setIdle(); ex_valid = 1; ex_pc = 32'h80000804; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      pulses += int'(EX_MEM_Exc);
    end
    checkOutput("stallPulses", pulses, 1);
    checkOutput("stallHeldPc", EX_MEM_PC, 32'h80000800);
    setIdle(); mem_stall = 0; applyStimulus();
    checkOutput("stallBubble", EX_MEM_valid, 0);

    // eret redirects to EPC and kills the next instruction
    ex_valid = 1; ex_pc = 32'h80000200; ex_eret = 1; applyStimulus();
    checkOutput("eretPulse", EX_MEM_eret_flush, 1);
    checkOutput("eretFlush", pipe_flush, 1);
    checkOutput("eretFlushPc", flush_pc, 32'h80002000);
    checkOutput("eretNoExc", EX_MEM_Exc, 0);
    setIdle(); ex_valid = 1; ex_pc = 32'h80000204; applyStimulus();
    checkOutput("eretKillNext", EX_MEM_valid, 0);
    checkOutput("eretOneShot", EX_MEM_eret_flush, 0);

    // eret plus overflow is only the exception
    ex_pc = 32'h80000208; ex_eret = 1; ex_ov = 1; applyStimulus();
    checkOutput("eretOvExc", EX_MEM_Exc, 1);
    checkOutput("eretOvNoEret", EX_MEM_eret_flush, 0);
    setIdle(); applyStimulus();

    // Reset while a delay-slot exception is held
    ex_valid = 1; ex_pc = 32'h80000300; ex_is_branch = 1; applyStimulus();
    setIdle(); ex_valid = 1; ex_pc = 32'h80000304; ex_load = 1; ex_mem_addr = 32'h5; ex_mem_size = 1;
    applyStimulus();
    checkOutput("preRstBd", EX_MEM_bd, 1);
    checkOutput("preRstExc", EX_MEM_Exc, 1);
    setIdle(); mem_stall = 1;
    #2 rst = 1;
    #1;
    checkOutput("midRstExc", EX_MEM_Exc, 0);
    checkOutput("midRstValid", EX_MEM_valid, 0);
    checkOutput("midRstBd", EX_MEM_bd, 0);
    @(posedge clk); #1 rst = 0; mem_stall = 0;
    applyStimulus();
    ex_valid = 1; ex_pc = 32'h80000900; applyStimulus();
    checkOutput("postRstPc", EX_MEM_PC, 32'h80000900);
    setIdle(); applyStimulus(); applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
